matrix_weight_sram_responder: RTL and testbench
===============================================

// Module: matrix_weight_sram_responder
// PURPOSE
//   Responder end of the matrix SRAM fetch interface used by the matvec engine. Holds the Q2.14
//   weight matrix (row-major, MAX_ROWS*MAX_COLS words) and answers each single-cycle matrix_enable
//   request with BANDWIDTH consecutive words plus a one-cycle matrix_ready pulse. The backing array
//   is narrow: WORDS_PER_CYCLE words are read per clock, so a response is assembled over several beats.
//   A word-wide host write port loads weights between inferences.
// PARAMETERS
//   MAX_ROWS         64  matrix rows supported
//   MAX_COLS         64  matrix columns supported
//   BANDWIDTH        16  words returned per request
//   DATA_WIDTH       16  bits per word (Q2.14)
//   WORDS_PER_CYCLE   4  words read from the array per clock; must divide BANDWIDTH
// PORTS
//   clk             in   1                              clock
//   rst_n           in   1                              reset, asynchronous, active-low
//   matrix_enable   in   1                              request strobe, sampled one cycle
//   matrix_addr     in   $clog2(MAX_ROWS*MAX_COLS)      base word address of request
//   matrix_data     out  DATA_WIDTH x BANDWIDTH (signed) response words, element i = mem[addr+i]
//   matrix_ready    out  1                              one-cycle response-valid pulse
//   busy            out  1                              high whenever state != S_IDLE
//   weight_we       in   1                              host write strobe
//   weight_waddr    in   $clog2(MAX_ROWS*MAX_COLS)      host write address
//   weight_wdata    in   DATA_WIDTH (signed)            host write data
//   weight_wready   out  1                              write accepted this cycle (combinational)
//   req_dropped     out  1                              sticky: request arrived while busy
// BEHAVIOUR
//   - Reset: state S_IDLE, matrix_ready=0, matrix_data all 0, req_dropped=0, beat counter 0.
//     Array contents are not reset and survive rst_n; reset mid-fetch abandons the response (no ready).
//   - N_BEATS = BANDWIDTH/WORDS_PER_CYCLE. States: S_IDLE -> S_FETCH -> S_RESP -> S_IDLE.
//   - S_IDLE: matrix_enable=1 latches matrix_addr, beat=0, -> S_FETCH.
//   - S_FETCH: each cycle issues synchronous read of words addr+beat*WPC .. +WPC-1; data returned
//     next cycle is written into matrix_data slots [beat*WPC +: WPC]. After beat N_BEATS-1 is
//     issued -> S_RESP (captures final beat).
//   - S_RESP: matrix_ready=1 for exactly this cycle; -> S_IDLE.
//   - Latency: enable sampled at edge of cycle T -> matrix_ready high during cycle T+N_BEATS+1
//     (T+5 at defaults). Ready never asserts in the request cycle.
//   - matrix_data holds its value from the ready cycle until the next response's beats overwrite
//     it; during S_FETCH partially updated contents are not valid.
//   - Out of range: any word with addr+i >= MAX_ROWS*MAX_COLS returns 0; no wrap-around.
//   - Address sum computed one bit wider than address to detect overflow.
//   - matrix_enable while busy: ignored, req_dropped set (cleared only by reset).
//   - Writes: weight_wready = (state==S_IDLE) && !matrix_enable. Write with we&&wready commits
//     mem[waddr] at the clock edge; otherwise dropped (host must retry). Request wins a
//     simultaneous enable+we in IDLE. Out-of-range waddr writes are discarded.
//   - Write then request to same address on next cycle returns the new value.
//   - busy is combinational from state.
// TESTING
//   - Load mem[i]=i (i=0..4095), request addr=0x020 -> ready exactly 5 cycles later, data[i]=0x20+i.
//   - Request addr=4088 -> data[0..7]=4088..4095, data[8..15]=0, ready at T+5.
//   - Second enable 2 cycles after first -> ignored, req_dropped=1, one ready pulse with first data.
//   - enable and we same IDLE cycle (waddr=5, wdata=0x7FFF) -> wready=0, mem[5] unchanged; retry writes.
//   - Write mem[100]=0x8000 then request addr=100 next cycle -> data[0]=0x8000 (signed -2.0).
//   - Assert rst_n low at T+3 of a fetch -> no ready, data=0, busy=0; mem contents preserved.

Source files
------------

// File: rtl/matrix_weight_sram_responder.sv
// Matrix weight SRAM responder: returns BANDWIDTH consecutive Q2.14 words per request,
// assembled over BANDWIDTH/WORDS_PER_CYCLE read beats, plus a word-wide host write port.
module matrix_weight_sram_responder #(
  parameter int MAX_ROWS        = 64,
  parameter int MAX_COLS        = 64,
  parameter int BANDWIDTH       = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int WORDS_PER_CYCLE = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        matrix_enable,
  input  logic [$clog2(MAX_ROWS*MAX_COLS)-1:0]        matrix_addr,
  output logic signed [BANDWIDTH-1:0][DATA_WIDTH-1:0] matrix_data,
  output logic                                        matrix_ready,
  output logic                                        busy,
  input  logic                                        weight_we,
  input  logic [$clog2(MAX_ROWS*MAX_COLS)-1:0]        weight_waddr,
  input  logic signed [DATA_WIDTH-1:0]                weight_wdata,
  output logic                                        weight_wready,
  output logic                                        req_dropped
);

  localparam int DEPTH   = MAX_ROWS * MAX_COLS;
  localparam int AW      = $clog2(DEPTH);
  localparam int WPC     = WORDS_PER_CYCLE;
  localparam int N_BEATS = BANDWIDTH / WORDS_PER_CYCLE;
  localparam int BTW     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  typedef logic [AW:0]    ext_t;
  typedef logic [BTW-1:0] beat_t;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

  localparam ext_t DEPTH_X = ext_t'(DEPTH);

  state_t                             state_q, state_d;
  logic [AW-1:0]                      base_q, base_d;
  beat_t                              beat_q, beat_d;
  logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] data_q;
  logic                               dropped_q;
  logic [DATA_WIDTH-1:0]              mem_q [DEPTH];
  ext_t                               rd_addr [WPC];
  logic [DATA_WIDTH-1:0]              rd_val  [WPC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (matrix_enable) begin
          state_d = S_FETCH;
          base_d  = matrix_addr;
          beat_d  = '0;
        end
      end
      S_FETCH: begin
        if (beat_q == beat_t'(N_BEATS - 1)) state_d = S_RESP;
        else                                beat_d  = beat_q + 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    matrix_ready  = (state_q == S_RESP);
    weight_wready = (state_q == S_IDLE) && !matrix_enable;
  end

  assign matrix_data = data_q;
  assign req_dropped = dropped_q;

  // Address sum is one bit wider than the address so overflow past the array reads as zero.
  always_comb begin
    for (int unsigned k = 0; k < WPC; k++) begin
      rd_addr[k] = {1'b0, base_q} + ext_t'(beat_q) * ext_t'(WPC) + ext_t'(k);
      rd_val[k]  = (rd_addr[k] < DEPTH_X) ? mem_q[rd_addr[k][AW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (weight_we && weight_wready && ({1'b0, weight_waddr} < DEPTH_X))
      mem_q[weight_waddr] <= weight_wdata;
  end

  // The synchronous read register is the output slot itself, so the last beat
  // lands in matrix_data on the same edge that enters S_RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      if (state_q == S_FETCH) begin
        for (int unsigned i = 0; i < BANDWIDTH; i++) begin
          if (beat_t'(i / WPC) == beat_q) data_q[i] <= rd_val[i % WPC];
        end
      end
      if (matrix_enable && (state_q != S_IDLE)) dropped_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_weight_sram_responder.sv
// Self-checking bench for matrix_weight_sram_responder: cycle-level reference model,
// per-cycle output comparison, and directed literal expectations.
module tb_matrix_weight_sram_responder;

  localparam int DEPTH   = 4096;
  localparam int BW      = 16;
  localparam int DW      = 16;
  localparam int N_BEATS = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 matrix_enable = 1'b0;
  logic [11:0]          matrix_addr = '0;
  logic [BW-1:0][DW-1:0] matrix_data;
  logic                 matrix_ready;
  logic                 busy;
  logic                 weight_we = 1'b0;
  logic [11:0]          weight_waddr = '0;
  logic [DW-1:0]        weight_wdata = '0;
  logic                 weight_wready;
  logic                 req_dropped;

  matrix_weight_sram_responder #(
    .MAX_ROWS(64), .MAX_COLS(64), .BANDWIDTH(BW), .DATA_WIDTH(DW), .WORDS_PER_CYCLE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .matrix_enable(matrix_enable), .matrix_addr(matrix_addr),
    .matrix_data(matrix_data), .matrix_ready(matrix_ready), .busy(busy),
    .weight_we(weight_we), .weight_waddr(weight_waddr), .weight_wdata(weight_wdata),
    .weight_wready(weight_wready), .req_dropped(req_dropped)
  );

  always #5 clk = ~clk;

  // Reference model: a request accepted in an idle cycle snapshots its words and is
  // answered N_BEATS+1 cycles after the request cycle; the responder is busy until then.
  logic [DW-1:0]         ref_mem [DEPTH];
  logic [BW-1:0][DW-1:0] pend = '0;
  logic [BW-1:0][DW-1:0] exp_data = '0;
  int                    cyc = 0;
  int                    resp_at = -1;
  logic                  dropped = 1'b0;
  logic                  m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_at  = -1;
      dropped  = 1'b0;
      exp_data = '0;
    end else begin
      cyc    = cyc + 1;
      m_busy = (resp_at >= 0) && (cyc - 1 <= resp_at);
      if (m_busy) begin
        if (matrix_enable) dropped = 1'b1;
      end else if (matrix_enable) begin
        resp_at = cyc + N_BEATS;
        for (int i = 0; i < BW; i++)
          pend[i] = (int'(matrix_addr) + i < DEPTH) ? ref_mem[int'(matrix_addr) + i] : '0;
      end else if (weight_we) begin
        ref_mem[weight_waddr] = weight_wdata;
      end
      if (cyc == resp_at) exp_data = pend;
    end
  end

  int   total = 0;
  int   bad   = 0;
  logic cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int k = 0; k < 12; k++) begin
      if (matrix_ready) begin
        n = k;
        break;
      end
      tick();
    end
  endtask

  task automatic request(input logic [11:0] a);
    matrix_enable = 1'b1;
    matrix_addr   = a;
    tick();
    matrix_enable = 1'b0;
  endtask

  task automatic compare();
    logic eb;
    eb = (resp_at >= 0) && (cyc <= resp_at);
    chk("busy", busy, eb);
    chk("ready", matrix_ready, (resp_at >= 0) && (cyc == resp_at));
    chk("wready", weight_wready, !eb && !matrix_enable);
    chk("dropped", req_dropped, dropped);
    if (!eb) chk("data", matrix_data, exp_data);
  endtask

  int n;
  int cnt;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (cmp_on) compare();
      end
    join_none

    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", matrix_ready, 1'b0);
    chk("rst_data", matrix_data, '0);
    chk("rst_dropped", req_dropped, 1'b0);
    rst_n = 1'b1;
    tick();
    cmp_on = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      weight_we    = 1'b1;
      weight_waddr = 12'(i);
      weight_wdata = 16'(i);
      tick();
    end
    weight_we = 1'b0;
    tick();

    request(12'h020);
    wait_ready(n);
    chk("t1_latency", n, N_BEATS);
    chk("t1_d0", matrix_data[0], 16'h0020);
    chk("t1_d15", matrix_data[15], 16'h002F);
    tick();

    request(12'd4088);
    wait_ready(n);
    chk("t2_latency", n, N_BEATS);
    chk("t2_d0", matrix_data[0], 16'd4088);
    chk("t2_d7", matrix_data[7], 16'd4095);
    chk("t2_d8", matrix_data[8], 16'h0000);
    chk("t2_d15", matrix_data[15], 16'h0000);
    tick();

    request(12'h100);
    tick();
    request(12'h200);
    wait_ready(n);
    chk("t3_latency", n, N_BEATS - 2);
    chk("t3_d0", matrix_data[0], 16'h0100);
    chk("t3_dropped", req_dropped, 1'b1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (matrix_ready) cnt++;
    end
    chk("t3_no_second_ready", cnt, 0);

    matrix_enable = 1'b1;
    matrix_addr   = 12'h000;
    weight_we     = 1'b1;
    weight_waddr  = 12'd5;
    weight_wdata  = 16'h7FFF;
    #1;
    chk("t4_wready_blocked", weight_wready, 1'b0);
    tick();
    matrix_enable = 1'b0;
    weight_we     = 1'b0;
    wait_ready(n);
    chk("t4_d5_unchanged", matrix_data[5], 16'h0005);
    tick();
    weight_we    = 1'b1;
    weight_waddr = 12'd5;
    weight_wdata = 16'h7FFF;
    #1;
    chk("t4_wready_idle", weight_wready, 1'b1);
    tick();
    weight_we = 1'b0;
    request(12'h000);
    wait_ready(n);
    chk("t4_d5_retry", matrix_data[5], 16'h7FFF);
    tick();

    weight_we    = 1'b1;
    weight_waddr = 12'd100;
    weight_wdata = 16'h8000;
    tick();
    weight_we = 1'b0;
    request(12'd100);
    wait_ready(n);
    chk("t5_latency", n, N_BEATS);
    chk("t5_d0", matrix_data[0], 16'h8000);
    chk("t5_d1", matrix_data[1], 16'd101);
    tick();

    request(12'h040);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", matrix_ready, 1'b0);
    chk("t6_data", matrix_data, '0);
    chk("t6_dropped", req_dropped, 1'b0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (matrix_ready) cnt++;
    end
    chk("t6_no_ready", cnt, 0);
    request(12'h040);
    wait_ready(n);
    chk("t6_mem_kept", matrix_data[0], 16'h0040);
    tick();

    for (int k = 0; k < 500; k++) begin
      matrix_enable = ($urandom_range(0, 3) == 0);
      matrix_addr   = ($urandom_range(0, 3) == 0) ? 12'(4080 + $urandom_range(0, 15))
                                                  : 12'($urandom_range(0, DEPTH - 1));
      weight_we     = $urandom_range(0, 1) != 0;
      weight_waddr  = 12'($urandom_range(0, DEPTH - 1));
      weight_wdata  = 16'($urandom);
      tick();
    end
    matrix_enable = 1'b0;
    weight_we     = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
